core_mem_arbiter: RTL and testbench

CORE_MEM_ARBITER -- requirements
Module: core_mem_arbiter

---
 rtl/core_mem_arb_pkg.sv | 27 ++
 rtl/rr_arbiter_2.sv | 50 +++++
 rtl/core_mem_arbiter.sv | 121 ++++++++++++
 tb/tb_core_mem_arbiter.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : core_mem_arb_pkg
// Description : Shared types and helpers for the core memory arbiter. Holds
//               the response-owner encoding and the word-index width helper
//               used to size the SRAM address port.
// Revision    : 1.0 - initial release
// ============================================================================
package core_mem_arb_pkg;

  // Which requester owns the SRAM response arriving in the current cycle.
  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_INSTR = 2'd1,
    OWN_DATA  = 2'd2
  } owner_e;

  // Byte-offset bits dropped when turning a byte address into a word index.
  localparam int C_BYTE_OFS_W = 2;

  // Number of word-index bits needed to address a SRAM of 'depth' words.
  function automatic int word_idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter_2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter_2
// Description : Two-way round-robin arbiter with a one-bit last-grant register.
//               A lone requester is granted at once; on contention the port
//               not granted most recently wins. The last-grant register only
//               moves on a grant, and resets to port 1 so port 0 wins first.
// Ports       : clk_i   - clock
//               reset_i - synchronous active-high reset
//               req_i   - request vector (bit 0 = instr, bit 1 = data)
//               gnt_o   - one-hot (or zero) grant vector, combinational
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter_2 (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  // 1 = port 1 was granted most recently, 0 = port 0 was.
  logic last_q;
  logic last_d;

  always_comb begin
    gnt_o = req_i;
    if (req_i == 2'b11) begin
      gnt_o = last_q ? 2'b01 : 2'b10;
    end
  end

  always_comb begin
    last_d = last_q;
    if (gnt_o[0]) begin
      last_d = 1'b0;
    end else if (gnt_o[1]) begin
      last_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/core_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : core_mem_arbiter
// Description : Shares one single-port SRAM between an instruction-fetch port
//               and a load/store port. Grants are combinational in the request
//               cycle, the SRAM responds one cycle later, and a response-owner
//               register steers that response back to the right requester.
//               Sustains one access per cycle; contention alternates grants.
// Ports       : clk_i, reset_i                    - clock, sync active-high reset
//               instr_req_i/addr_i                - fetch request
//               instr_gnt_o/rvalid_o/rdata_o      - fetch grant and response
//               data_req_i/we_i/be_i/addr_i/wdata_i - load/store request
//               data_gnt_o/rvalid_o/rdata_o       - load/store grant and response
//               mem_en_o/we_o/addr_o/wdata_o      - SRAM command
//               mem_rdata_i                       - SRAM read data (1-cycle latency)
// Revision    : 1.0 - initial release
// ============================================================================
module core_mem_arbiter
  import core_mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 2048,
  localparam int IDX_W     = word_idx_width(MEM_DEPTH),
  localparam int BE_W      = DATA_WIDTH / 8
) (
  input  logic                  clk_i,
  input  logic                  reset_i,

  input  logic                  instr_req_i,
  input  logic [ADDR_WIDTH-1:0] instr_addr_i,
  output logic                  instr_gnt_o,
  output logic                  instr_rvalid_o,
  output logic [DATA_WIDTH-1:0] instr_rdata_o,

  input  logic                  data_req_i,
  input  logic                  data_we_i,
  input  logic [BE_W-1:0]       data_be_i,
  input  logic [ADDR_WIDTH-1:0] data_addr_i,
  input  logic [DATA_WIDTH-1:0] data_wdata_i,
  output logic                  data_gnt_o,
  output logic                  data_rvalid_o,
  output logic [DATA_WIDTH-1:0] data_rdata_o,

  output logic                  mem_en_o,
  output logic [BE_W-1:0]       mem_we_o,
  output logic [IDX_W-1:0]      mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  logic [1:0] req_w;
  logic [1:0] gnt_w;
  owner_e     owner_q;
  owner_e     owner_d;

  // Requests are masked during reset so no grant (and no last-grant update)
  // can happen while the block is held in reset.
  assign req_w = {data_req_i, instr_req_i} & {2{~reset_i}};

  rr_arbiter_2 u_rr (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .req_i   (req_w),
    .gnt_o   (gnt_w)
  );

  assign instr_gnt_o = gnt_w[0];
  assign data_gnt_o  = gnt_w[1];

  // Word index: drop the byte offset and everything above the SRAM size, so
  // addresses simply wrap modulo MEM_DEPTH words.
  logic [IDX_W-1:0] instr_idx_w;
  logic [IDX_W-1:0] data_idx_w;
  assign instr_idx_w = instr_addr_i[IDX_W+C_BYTE_OFS_W-1:C_BYTE_OFS_W];
  assign data_idx_w  = data_addr_i[IDX_W+C_BYTE_OFS_W-1:C_BYTE_OFS_W];

  // Byte-offset and above-SRAM address bits carry no meaning here.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{instr_addr_i, data_addr_i};

  always_comb begin
    mem_en_o    = 1'b0;
    mem_we_o    = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    owner_d     = OWN_NONE;
    if (gnt_w[0]) begin
      mem_en_o   = 1'b1;
      mem_addr_o = instr_idx_w;
      owner_d    = OWN_INSTR;
    end else if (gnt_w[1]) begin
      mem_en_o   = 1'b1;
      mem_addr_o = data_idx_w;
      owner_d    = OWN_DATA;
      if (data_we_i) begin
        mem_we_o    = data_be_i;
        mem_wdata_o = data_wdata_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      owner_q <= OWN_NONE;
    end else begin
      owner_q <= owner_d;
    end
  end

  // owner_q still holds the pre-reset owner during the first reset cycle, so
  // the strobes are also gated by reset_i; this is what kills the response of
  // a grant that is followed directly by reset.
  assign instr_rvalid_o = ~reset_i & (owner_q == OWN_INSTR);
  assign data_rvalid_o  = ~reset_i & (owner_q == OWN_DATA);

  assign instr_rdata_o = instr_rvalid_o ? mem_rdata_i : '0;
  assign data_rdata_o  = data_rvalid_o  ? mem_rdata_i : '0;

endmodule
`default_nettype wire

// File: tb/tb_core_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_core_mem_arbiter
// Description : Directed self-checking bench for core_mem_arbiter. Inputs are
//               changed 1 ns after the rising edge and outputs are sampled
//               1 ns later, well clear of the next edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_core_mem_arbiter;

  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  localparam int MEM_DEPTH  = 2048;
  localparam int IDX_W      = 11;

  logic                  clk_i = 1'b0;
  logic                  reset_i;
  logic                  instr_req_i;
  logic [ADDR_WIDTH-1:0] instr_addr_i;
  logic                  instr_gnt_o;
  logic                  instr_rvalid_o;
  logic [DATA_WIDTH-1:0] instr_rdata_o;
  logic                  data_req_i;
  logic                  data_we_i;
  logic [3:0]            data_be_i;
  logic [ADDR_WIDTH-1:0] data_addr_i;
  logic [DATA_WIDTH-1:0] data_wdata_i;
  logic                  data_gnt_o;
  logic                  data_rvalid_o;
  logic [DATA_WIDTH-1:0] data_rdata_o;
  logic                  mem_en_o;
  logic [3:0]            mem_we_o;
  logic [IDX_W-1:0]      mem_addr_o;
  logic [DATA_WIDTH-1:0] mem_wdata_o;
  logic [DATA_WIDTH-1:0] mem_rdata_i;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_i = ~clk_i;

  core_mem_arbiter #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH)
  ) dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .instr_req_i    (instr_req_i),
    .instr_addr_i   (instr_addr_i),
    .instr_gnt_o    (instr_gnt_o),
    .instr_rvalid_o (instr_rvalid_o),
    .instr_rdata_o  (instr_rdata_o),
    .data_req_i     (data_req_i),
    .data_we_i      (data_we_i),
    .data_be_i      (data_be_i),
    .data_addr_i    (data_addr_i),
    .data_wdata_i   (data_wdata_i),
    .data_gnt_o     (data_gnt_o),
    .data_rvalid_o  (data_rvalid_o),
    .data_rdata_o   (data_rdata_o),
    .mem_en_o       (mem_en_o),
    .mem_we_o       (mem_we_o),
    .mem_addr_o     (mem_addr_o),
    .mem_wdata_o    (mem_wdata_o),
    .mem_rdata_i    (mem_rdata_i)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    instr_req_i  = 1'b0;
    instr_addr_i = '0;
    data_req_i   = 1'b0;
    data_we_i    = 1'b0;
    data_be_i    = '0;
    data_addr_i  = '0;
    data_wdata_i = '0;
    mem_rdata_i  = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_i = 1'b1;
    tick();
    tick();
    reset_i = 1'b0;
  endtask

  // Expected grant sequence under sustained contention straight after reset.
  logic [1:0] exp_gnt [4] = '{2'b01, 2'b10, 2'b01, 2'b10};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    reset_i = 1'b1;

    // ---- Reset holds every output low even with requests pending ----------
    tick();
    instr_req_i  = 1'b1;
    instr_addr_i = 32'h0000_0010;
    data_req_i   = 1'b1;
    data_we_i    = 1'b1;
    data_be_i    = 4'hF;
    data_wdata_i = 32'hCAFE_F00D;
    mem_rdata_i  = 32'h1234_5678;
    settle();
    check("rst_gnt",    {30'd0, data_gnt_o, instr_gnt_o}, 32'd0);
    check("rst_mem_en", {31'd0, mem_en_o}, 32'd0);
    check("rst_mem_we", {28'd0, mem_we_o}, 32'd0);
    check("rst_mem_wd", mem_wdata_o, 32'd0);
    check("rst_mem_ad", {21'd0, mem_addr_o}, 32'd0);
    check("rst_rvalid", {30'd0, data_rvalid_o, instr_rvalid_o}, 32'd0);
    check("rst_rdata",  instr_rdata_o | data_rdata_o, 32'd0);
    do_reset();

    // ---- Contention for 4 cycles: I,D,I,D with matching responses ---------
    instr_req_i  = 1'b1;
    instr_addr_i = 32'h0000_0020;  // word 8
    data_req_i   = 1'b1;
    data_we_i    = 1'b0;
    data_be_i    = 4'hF;
    data_addr_i  = 32'h0000_0040;  // word 16
    data_wdata_i = 32'hFFFF_FFFF;
    for (int k = 0; k < 4; k++) begin
      mem_rdata_i = 32'hA000_0000 + k;
      settle();
      check($sformatf("alt_gnt%0d", k), {30'd0, data_gnt_o, instr_gnt_o}, {30'd0, exp_gnt[k]});
      check($sformatf("alt_addr%0d", k), {21'd0, mem_addr_o},
            (exp_gnt[k] == 2'b01) ? 32'd8 : 32'd16);
      check($sformatf("alt_we%0d", k), {28'd0, mem_we_o}, 32'd0);
      check($sformatf("alt_wd%0d", k), mem_wdata_o, 32'd0);
      if (k > 0) begin
        check($sformatf("alt_rv%0d", k), {30'd0, data_rvalid_o, instr_rvalid_o},
              {30'd0, exp_gnt[k-1]});
        check($sformatf("alt_rd%0d", k),
              (exp_gnt[k-1] == 2'b01) ? instr_rdata_o : data_rdata_o, 32'hA000_0000 + k);
      end else begin
        check("alt_rv0", {30'd0, data_rvalid_o, instr_rvalid_o}, 32'd0);
      end
      tick();
    end
    idle_inputs();
    mem_rdata_i = 32'hB0B0_0004;
    settle();
    check("alt_rv_last", {30'd0, data_rvalid_o, instr_rvalid_o}, 32'd2);
    check("alt_rd_last", data_rdata_o, 32'hB0B0_0004);
    check("alt_ird_zero", instr_rdata_o, 32'd0);
    check("alt_no_gnt", {30'd0, data_gnt_o, instr_gnt_o}, 32'd0);
    tick();

    // ---- Single instruction fetch at 0x10 ---------------------------------
    instr_req_i  = 1'b1;
    instr_addr_i = 32'h0000_0010;
    settle();
    check("if_gnt",    {30'd0, data_gnt_o, instr_gnt_o}, 32'd1);
    check("if_en",     {31'd0, mem_en_o}, 32'd1);
    check("if_addr",   {21'd0, mem_addr_o}, 32'd4);
    check("if_we",     {28'd0, mem_we_o}, 32'd0);
    tick();
    idle_inputs();
    mem_rdata_i = 32'hDEAD_BEEF;
    settle();
    check("if_rvalid", {30'd0, data_rvalid_o, instr_rvalid_o}, 32'd1);
    check("if_rdata",  instr_rdata_o, 32'hDEAD_BEEF);
    check("if_drdata", data_rdata_o, 32'd0);
    check("if_dropped", {31'd0, mem_en_o}, 32'd0);
    tick();
    settle();
    check("if_rv_once", {30'd0, data_rvalid_o, instr_rvalid_o}, 32'd0);
    check("if_rd_idle", instr_rdata_o, 32'd0);

    // ---- Data write: be=0101, wdata=0x11223344, addr 0x8 -------------------
    data_req_i   = 1'b1;
    data_we_i    = 1'b1;
    data_be_i    = 4'b0101;
    data_addr_i  = 32'h0000_0008;
    data_wdata_i = 32'h1122_3344;
    settle();
    check("wr_gnt",  {30'd0, data_gnt_o, instr_gnt_o}, 32'd2);
    check("wr_we",   {28'd0, mem_we_o}, 32'b0101);
    check("wr_addr", {21'd0, mem_addr_o}, 32'd2);
    check("wr_wd",   mem_wdata_o, 32'h1122_3344);
    tick();
    idle_inputs();
    mem_rdata_i = 32'h55AA_55AA;
    settle();
    check("wr_rvalid", {30'd0, data_rvalid_o, instr_rvalid_o}, 32'd2);
    check("wr_rdata",  data_rdata_o, 32'h55AA_55AA);
    tick();

    // ---- Address wrap modulo MEM_DEPTH words -------------------------------
    instr_req_i  = 1'b1;
    instr_addr_i = 32'h0000_2004;
    settle();
    check("wrap_i_addr", {21'd0, mem_addr_o}, 32'd1);
    tick();
    idle_inputs();
    data_req_i  = 1'b1;
    data_addr_i = 32'hFFFF_FFFC;
    settle();
    check("wrap_d_addr", {21'd0, mem_addr_o}, 32'd2047);
    check("wrap_d_wd",   mem_wdata_o, 32'd0);
    tick();
    idle_inputs();

    // ---- Reset right after a data grant kills its response ----------------
    data_req_i  = 1'b1;
    data_addr_i = 32'h0000_000C;
    settle();
    check("rg_gnt", {30'd0, data_gnt_o, instr_gnt_o}, 32'd2);
    tick();
    idle_inputs();
    reset_i     = 1'b1;
    instr_req_i = 1'b1;
    mem_rdata_i = 32'h7777_7777;
    settle();
    check("rg_no_rvalid", {30'd0, data_rvalid_o, instr_rvalid_o}, 32'd0);
    check("rg_no_rdata",  data_rdata_o, 32'd0);
    check("rg_no_gnt",    {30'd0, data_gnt_o, instr_gnt_o}, 32'd0);
    tick();
    reset_i      = 1'b0;
    instr_req_i  = 1'b1;
    instr_addr_i = 32'h0000_0000;
    data_req_i   = 1'b1;
    settle();
    check("rg_rv_after", {30'd0, data_rvalid_o, instr_rvalid_o}, 32'd0);
    check("rg_first_i",  {30'd0, data_gnt_o, instr_gnt_o}, 32'd1);
    tick();
    settle();
    check("rg_then_d",   {30'd0, data_gnt_o, instr_gnt_o}, 32'd2);
    tick();
    idle_inputs();
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
